// File: rtl/vga1306_link_tx.sv
// Transmit end of the VGA1306 framebuffer write link: SSD1306-ordered bytes onto wclk/write_en/din/cs.
// Define VGA1306_TX_PATTERN_EN to add pattern_req and an internal checkerboard frame generator.
module vga1306_link_tx #(
    parameter int CLK_DIV         = 2,
    parameter int BYTES_PER_FRAME = 1024,
    parameter int SYNC_EDGES      = 2
) (
    input  logic       CLK25MHz,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_sof,
    output logic       s_ready,
    input  logic       invert,
`ifdef VGA1306_TX_PATTERN_EN
    input  logic       pattern_req,
`endif
    output logic       wclk,
    output logic       write_en,
    output logic [1:0] din,
    output logic       cs,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int SYNC_W = $clog2(SYNC_EDGES) + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST  = SYNC_W'(SYNC_EDGES - 1);
    localparam logic [10:0]       COUNT_LAST = 11'(BYTES_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT, FETCH} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_byte;
    logic [10:0]         r_count;
    logic [2:0]          r_bit;
    logic [DIV_W-1:0]    r_div;
    logic [SYNC_W-1:0]   r_sync;
    logic                r_wclk;
    logic                r_we;
    logic                r_din0;
    logic                r_cs;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_half_end;
    logic                w_period_end;
    logic                w_frame_end;
    logic [2:0]          w_bit_nxt;
    logic                w_start;
    logic                w_next;
    logic                w_err;
    logic [7:0]          w_new_byte;

`ifdef VGA1306_TX_PATTERN_EN
    logic                r_pat;
    logic                w_pat_start;

    function automatic logic [7:0] pattern_byte(input logic odd);
        return odd ? 8'h55 : 8'hAA;
    endfunction

    // pattern_req takes priority over the host stream while idle
    assign w_pat_start = (r_state == IDLE) && pattern_req && !reset;
    assign s_ready     = ((r_state == IDLE && !pattern_req) || r_state == FETCH) && !reset;
`else
    assign s_ready     = (r_state == IDLE || r_state == FETCH) && !reset;
`endif

    assign w_accept     = s_valid && s_ready;
    assign w_half_end   = (r_div == DIV_LAST);
    assign w_period_end = w_half_end && r_wclk;
    assign w_frame_end  = (r_state == SHIFT) && w_period_end && (r_bit == 3'd7) && (r_count == COUNT_LAST);
    assign w_bit_nxt    = r_bit + 3'd1;

    always_ff @(posedge CLK25MHz) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_next      = 1'b0;
        w_err       = 1'b0;
        w_new_byte  = s_data;
        case (r_state)
            IDLE: begin
`ifdef VGA1306_TX_PATTERN_EN
                if (w_pat_start) begin
                    w_start     = 1'b1;
                    w_new_byte  = pattern_byte(1'b0);
                    w_state_nxt = SYNC;
                end else
`endif
                if (w_accept) begin
                    if (s_sof) begin
                        w_start     = 1'b1;
                        w_state_nxt = SYNC;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (w_period_end && r_sync == SYNC_LAST) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_period_end && r_bit == 3'd7) begin
                    if (r_count == COUNT_LAST) w_state_nxt = IDLE;
`ifdef VGA1306_TX_PATTERN_EN
                    else if (r_pat) begin
                        w_next     = 1'b1;
                        w_new_byte = pattern_byte(!r_count[0]);
                    end
`endif
                    else w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                // an sof here means the host abandoned the frame; restart with a fresh SYNC
                if (w_accept) begin
                    if (s_sof) begin
                        w_start     = 1'b1;
                        w_err       = 1'b1;
                        w_state_nxt = SYNC;
                    end else begin
                        w_next      = 1'b1;
                        w_state_nxt = SHIFT;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK25MHz) begin
        if (reset) begin
            r_count <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_sync  <= '0;
            r_wclk  <= 1'b0;
            r_we    <= 1'b0;
            r_din0  <= 1'b0;
            r_cs    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            r_err  <= w_err;
            if (w_start) begin
                r_byte  <= w_new_byte;
                r_cs    <= invert;
                r_count <= '0;
                r_div   <= '0;
                r_sync  <= '0;
                r_wclk  <= 1'b0;
                r_we    <= 1'b0;
                r_din0  <= 1'b0;
            end else if (w_next) begin
                r_byte  <= w_new_byte;
                r_count <= r_count + 11'd1;
                r_bit   <= '0;
                r_div   <= '0;
                r_wclk  <= 1'b0;
                r_we    <= 1'b1;
                r_din0  <= w_new_byte[0];
            end else if (r_state == SYNC || r_state == SHIFT) begin
                // each period: CLK_DIV cycles low, CLK_DIV high; data changes only at period end
                if (!w_half_end) begin
                    r_div <= r_div + DIV_W'(1);
                end else begin
                    r_div  <= '0;
                    r_wclk <= !r_wclk;
                    if (r_wclk) begin
                        if (r_state == SYNC) begin
                            r_sync <= r_sync + SYNC_W'(1);
                            if (r_sync == SYNC_LAST) begin
                                r_bit  <= '0;
                                r_we   <= 1'b1;
                                r_din0 <= r_byte[0];
                            end
                        end else if (r_bit != 3'd7) begin
                            r_bit  <= w_bit_nxt;
                            r_din0 <= r_byte[w_bit_nxt];
                        end else if (w_frame_end) begin
                            r_we <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef VGA1306_TX_PATTERN_EN
    always_ff @(posedge CLK25MHz) begin
        if (reset)            r_pat <= 1'b0;
        else if (w_pat_start) r_pat <= 1'b1;
        else if (w_frame_end) r_pat <= 1'b0;
    end
`endif

    assign wclk       = r_wclk;
    assign write_en   = r_we;
    assign din        = {1'b0, r_din0};
    assign cs         = r_cs;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_done;
    assign err        = r_err;
endmodule
